// File: rtl/qpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qpi_pkg
//  Description : Shared QPI read-path widths and the registered read-request
//                record used by qpi_rd_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package qpi_pkg;

    localparam int c_addr_w  = 20;   // QPI read address width
    localparam int c_mdata_w = 14;   // QPI metadata width: {id, local tag}
    localparam int c_data_w  = 512;  // QPI read data width
    localparam int c_id_w    = 2;    // requester id carried in mdata[13:12]
    localparam int c_tag_w   = 12;   // requester-local tag width
    localparam int c_cnt_w   = 6;    // outstanding counter width (limit up to 63)

    typedef struct packed {
        logic [c_addr_w-1:0]  addr;
        logic [c_mdata_w-1:0] mdata;
    } qpi_rd_req_t;

endpackage : qpi_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin selector. The search starts at
//                (i_last + 1) mod NUM_REQ; the first set request bit wins.
//  Ports       : i_req       - request vector
//                i_last      - index of the previous winner
//                o_grant     - one-hot grant vector
//                o_grant_idx - index of the winner (i_last when none)
//                o_valid     - any request granted
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_valid
);

    logic [PTR_W-1:0] w_idx;

    // NUM_REQ is a power of two, so modulo is plain wrap-around of the index.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = i_last;
        o_valid     = 1'b0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = i_last + PTR_W'(k);
            if (!o_valid && i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/qpi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : qpi_rd_arbiter
//  Description : Round-robin arbiter merging NUM_REQ read requesters onto one
//                QPI read-request port, tagging each request with the
//                requester id, and routing read responses back by that id.
//                Per-requester outstanding reads are limited to MAX_OUTST.
//  Ports       : clk / reset (async, active low)
//                io_req_*        - requester side (valid/addr/mdata/ready)
//                io_qpi_rd_req_* - registered QPI read request
//                io_qpi_rd_rsp_* - QPI read response in
//                io_rsp_*        - registered, routed response
//                io_idle         - nothing outstanding, no request pending
//  Options     : QPI_RD_ARB_PERF_EN adds io_perf_grants / io_perf_stalls,
//                saturating 32-bit event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module qpi_rd_arbiter
    import qpi_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           io_req_valid,
    input  logic [NUM_REQ*c_addr_w-1:0]  io_req_addr,
    input  logic [NUM_REQ*c_tag_w-1:0]   io_req_mdata,
    output logic [NUM_REQ-1:0]           io_req_ready,
    input  logic                         io_qpi_rd_req_almostfull,
    output logic [c_addr_w-1:0]          io_qpi_rd_req_addr,
    output logic [c_mdata_w-1:0]         io_qpi_rd_req_mdata,
    output logic                         io_qpi_rd_req_valid,
    input  logic                         io_qpi_rd_rsp_valid,
    input  logic [c_mdata_w-1:0]         io_qpi_rd_rsp_mdata,
    input  logic [c_data_w-1:0]          io_qpi_rd_rsp_data,
    output logic [NUM_REQ-1:0]           io_rsp_valid,
    output logic [c_tag_w-1:0]           io_rsp_mdata,
    output logic [c_data_w-1:0]          io_rsp_data,
`ifdef QPI_RD_ARB_PERF_EN
    output logic [31:0]                  io_perf_grants,
    output logic [31:0]                  io_perf_stalls,
`endif
    output logic                         io_idle
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [c_cnt_w-1:0]  r_outst_q [NUM_REQ];
    logic [c_cnt_w-1:0]  w_outst_d [NUM_REQ];
    logic [c_ptr_w-1:0]  r_last_grant_q, w_last_grant_d;
    logic                r_req_valid_q, w_req_valid_d;
    qpi_rd_req_t         r_req_q, w_req_d;
    logic [NUM_REQ-1:0]  r_rsp_valid_q;
    logic [c_tag_w-1:0]  r_rsp_mdata_q, w_rsp_mdata_d;
    logic [c_data_w-1:0] r_rsp_data_q, w_rsp_data_d;

    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_grant;
    logic [c_ptr_w-1:0]  w_grant_idx;
    logic                w_grant_any;
    logic                w_accept;
    logic [NUM_REQ-1:0]  w_rsp_hit;
    logic                w_all_zero;

    // A requester at its outstanding limit is skipped so it cannot block
    // the others from being selected.
    always_comb begin
        w_eligible = '0;
        w_rsp_hit  = '0;
        w_all_zero = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = io_req_valid[i] && (r_outst_q[i] < c_cnt_w'(MAX_OUTST));
            // Ids beyond NUM_REQ never match, and a zero count drops stale responses.
            w_rsp_hit[i]  = io_qpi_rd_rsp_valid
                          && (io_qpi_rd_rsp_mdata[c_mdata_w-1:c_tag_w] == c_id_w'(i))
                          && (r_outst_q[i] != '0);
            if (r_outst_q[i] != '0) begin
                w_all_zero = 1'b0;
            end
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr_arbiter (
        .i_req       (w_eligible),
        .i_last      (r_last_grant_q),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_valid     (w_grant_any)
    );

    assign w_accept     = w_grant_any && !io_qpi_rd_req_almostfull;
    assign io_req_ready = w_grant & {NUM_REQ{!io_qpi_rd_req_almostfull}};

    always_comb begin
        w_req_valid_d  = w_accept;
        w_req_d        = r_req_q;
        w_last_grant_d = r_last_grant_q;
        w_rsp_mdata_d  = r_rsp_mdata_q;
        w_rsp_data_d   = r_rsp_data_q;
        if (w_accept) begin
            w_last_grant_d = w_grant_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    w_req_d.addr  = io_req_addr[i*c_addr_w +: c_addr_w];
                    w_req_d.mdata = {c_id_w'(i), io_req_mdata[i*c_tag_w +: c_tag_w]};
                end
            end
        end
        if (|w_rsp_hit) begin
            w_rsp_mdata_d = io_qpi_rd_rsp_mdata[c_tag_w-1:0];
            w_rsp_data_d  = io_qpi_rd_rsp_data;
        end
        // Simultaneous accept and routed response cancel out.
        for (int i = 0; i < NUM_REQ; i++) begin
            w_outst_d[i] = r_outst_q[i];
            if (io_req_ready[i] && !w_rsp_hit[i]) begin
                w_outst_d[i] = r_outst_q[i] + c_cnt_w'(1);
            end else if (w_rsp_hit[i] && !io_req_ready[i]) begin
                w_outst_d[i] = r_outst_q[i] - c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant_q <= c_ptr_w'(NUM_REQ - 1);
            r_req_valid_q  <= 1'b0;
            r_req_q        <= '0;
            r_rsp_valid_q  <= '0;
            r_rsp_mdata_q  <= '0;
            r_rsp_data_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_outst_q[i] <= '0;
            end
        end else begin
            r_last_grant_q <= w_last_grant_d;
            r_req_valid_q  <= w_req_valid_d;
            r_req_q        <= w_req_d;
            r_rsp_valid_q  <= w_rsp_hit;
            r_rsp_mdata_q  <= w_rsp_mdata_d;
            r_rsp_data_q   <= w_rsp_data_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_outst_q[i] <= w_outst_d[i];
            end
        end
    end

    assign io_qpi_rd_req_valid = r_req_valid_q;
    assign io_qpi_rd_req_addr  = r_req_q.addr;
    assign io_qpi_rd_req_mdata = r_req_q.mdata;
    assign io_rsp_valid        = r_rsp_valid_q;
    assign io_rsp_mdata        = r_rsp_mdata_q;
    assign io_rsp_data         = r_rsp_data_q;
    assign io_idle             = w_all_zero && !r_req_valid_q;

`ifdef QPI_RD_ARB_PERF_EN
    logic [31:0] r_perf_grants_q, w_perf_grants_d;
    logic [31:0] r_perf_stalls_q, w_perf_stalls_d;

    always_comb begin
        w_perf_grants_d = r_perf_grants_q;
        w_perf_stalls_d = r_perf_stalls_q;
        if (w_accept && (r_perf_grants_q != '1)) begin
            w_perf_grants_d = r_perf_grants_q + 32'd1;
        end
        if ((|io_req_valid) && !w_accept && (r_perf_stalls_q != '1)) begin
            w_perf_stalls_d = r_perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_grants_q <= '0;
            r_perf_stalls_q <= '0;
        end else begin
            r_perf_grants_q <= w_perf_grants_d;
            r_perf_stalls_q <= w_perf_stalls_d;
        end
    end

    assign io_perf_grants = r_perf_grants_q;
    assign io_perf_stalls = r_perf_stalls_q;
`endif

endmodule : qpi_rd_arbiter
`default_nettype wire

// File: tb/tb_qpi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qpi_rd_arbiter
//  Description : Self-checking bench for qpi_rd_arbiter: directed scenarios
//                followed by randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qpi_rd_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_OUTST = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    io_req_valid;
    logic [NUM_REQ*20-1:0] io_req_addr;
    logic [NUM_REQ*12-1:0] io_req_mdata;
    logic [NUM_REQ-1:0]    io_req_ready;
    logic                  io_qpi_rd_req_almostfull;
    logic [19:0]           io_qpi_rd_req_addr;
    logic [13:0]           io_qpi_rd_req_mdata;
    logic                  io_qpi_rd_req_valid;
    logic                  io_qpi_rd_rsp_valid;
    logic [13:0]           io_qpi_rd_rsp_mdata;
    logic [511:0]          io_qpi_rd_rsp_data;
    logic [NUM_REQ-1:0]    io_rsp_valid;
    logic [11:0]           io_rsp_mdata;
    logic [511:0]          io_rsp_data;
    logic                  io_idle;
`ifdef QPI_RD_ARB_PERF_EN
    logic [31:0]           io_perf_grants;
    logic [31:0]           io_perf_stalls;
`endif

    qpi_rd_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .io_req_valid             (io_req_valid),
        .io_req_addr              (io_req_addr),
        .io_req_mdata             (io_req_mdata),
        .io_req_ready             (io_req_ready),
        .io_qpi_rd_req_almostfull (io_qpi_rd_req_almostfull),
        .io_qpi_rd_req_addr       (io_qpi_rd_req_addr),
        .io_qpi_rd_req_mdata      (io_qpi_rd_req_mdata),
        .io_qpi_rd_req_valid      (io_qpi_rd_req_valid),
        .io_qpi_rd_rsp_valid      (io_qpi_rd_rsp_valid),
        .io_qpi_rd_rsp_mdata      (io_qpi_rd_rsp_mdata),
        .io_qpi_rd_rsp_data       (io_qpi_rd_rsp_data),
        .io_rsp_valid             (io_rsp_valid),
        .io_rsp_mdata             (io_rsp_mdata),
        .io_rsp_data              (io_rsp_data),
`ifdef QPI_RD_ARB_PERF_EN
        .io_perf_grants           (io_perf_grants),
        .io_perf_stalls           (io_perf_stalls),
`endif
        .io_idle                  (io_idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int           m_outst [NUM_REQ];
    int           m_last;
    logic         m_qv;
    logic [19:0]  m_qaddr;
    logic [13:0]  m_qmd;
    logic [NUM_REQ-1:0] m_rv;
    logic [11:0]  m_rmd;
    logic [511:0] m_rdata;
    int           m_grants;
    int           m_stalls;
    logic [13:0]  pend [$];

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REQ; i++) m_outst[i] = 0;
        m_last   = NUM_REQ - 1;
        m_qv     = 1'b0;
        m_qaddr  = '0;
        m_qmd    = '0;
        m_rv     = '0;
        m_rmd    = '0;
        m_rdata  = '0;
        m_grants = 0;
        m_stalls = 0;
        pend.delete();
    endtask

    task automatic clear_inputs();
        io_req_valid             = '0;
        io_req_addr              = '0;
        io_req_mdata             = '0;
        io_qpi_rd_req_almostfull = 1'b0;
        io_qpi_rd_rsp_valid      = 1'b0;
        io_qpi_rd_rsp_mdata      = '0;
        io_qpi_rd_rsp_data       = '0;
    endtask

    task automatic set_req(input int i, input logic [19:0] a, input logic [11:0] t);
        io_req_valid[i]          = 1'b1;
        io_req_addr[i*20 +: 20]  = a;
        io_req_mdata[i*12 +: 12] = t;
    endtask

    task automatic send_rsp(input logic [13:0] md, input logic [511:0] d);
        io_qpi_rd_rsp_valid = 1'b1;
        io_qpi_rd_rsp_mdata = md;
        io_qpi_rd_rsp_data  = d;
    endtask

    // Winner by the round-robin rule: first valid requester below its limit,
    // searching upward from the previous winner; none while almost full.
    function automatic int model_pick();
        if (io_qpi_rd_req_almostfull) return -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i = (m_last + k) % NUM_REQ;
            if (io_req_valid[i] && m_outst[i] < MAX_OUTST) return i;
        end
        return -1;
    endfunction

    function automatic logic model_idle();
        for (int i = 0; i < NUM_REQ; i++) if (m_outst[i] != 0) return 1'b0;
        return !m_qv;
    endfunction

    // One clock: compare at the falling edge, advance the model, then return
    // just after the rising edge with the response input cleared.
    task automatic step();
        int g;
        int rid;
        logic [NUM_REQ-1:0] exp_rdy;
        @(negedge clk);
        g = model_pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready", io_req_ready, exp_rdy);
        check_eq("rd_req_valid", io_qpi_rd_req_valid, m_qv);
        check_eq("rd_req_addr", io_qpi_rd_req_addr, m_qaddr);
        check_eq("rd_req_mdata", io_qpi_rd_req_mdata, m_qmd);
        check_eq("rsp_valid", io_rsp_valid, m_rv);
        if (m_rv != '0) begin
            check_eq("rsp_mdata", io_rsp_mdata, m_rmd);
            check_eq("rsp_data", io_rsp_data, m_rdata);
        end
        check_eq("idle", io_idle, model_idle());

        rid  = int'(io_qpi_rd_rsp_mdata[13:12]);
        m_rv = '0;
        if (io_qpi_rd_rsp_valid && rid < NUM_REQ && m_outst[rid] > 0) begin
            m_rv[rid] = 1'b1;
            m_rmd     = io_qpi_rd_rsp_mdata[11:0];
            m_rdata   = io_qpi_rd_rsp_data;
            m_outst[rid]--;
        end
        if (g >= 0) begin
            m_qv    = 1'b1;
            m_qaddr = io_req_addr[g*20 +: 20];
            m_qmd   = {2'(g), io_req_mdata[g*12 +: 12]};
            m_outst[g]++;
            m_last  = g;
            m_grants++;
            pend.push_back(m_qmd);
        end else begin
            m_qv = 1'b0;
            if (io_req_valid != '0) m_stalls++;
        end
        @(posedge clk);
        #1;
        io_qpi_rd_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_eq("rst_rd_req_valid", io_qpi_rd_req_valid, 1'b0);
        check_eq("rst_rd_req_addr", io_qpi_rd_req_addr, 20'h0);
        check_eq("rst_rd_req_mdata", io_qpi_rd_req_mdata, 14'h0);
        check_eq("rst_rsp_valid", io_rsp_valid, '0);
        check_eq("rst_rsp_mdata", io_rsp_mdata, 12'h0);
        check_eq("rst_rsp_data", io_rsp_data, 512'h0);
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_idle", io_idle, 1'b1);
    endtask

    initial begin
        logic [511:0] d;
        clear_inputs();
        do_reset();

        // Alternating grants between requesters 0 and 2
        set_req(0, 20'h11111, 12'h001);
        set_req(2, 20'h22222, 12'h002);
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("rr_alt_id", io_qpi_rd_req_mdata[13:12], (k % 2 == 0) ? 2'd0 : 2'd2);
        end
        clear_inputs();

        // Single request/response round trip on requester 1
        set_req(1, 20'h00ABC, 12'h055);
        step();
        check_eq("rt_addr", io_qpi_rd_req_addr, 20'h00ABC);
        check_eq("rt_mdata", io_qpi_rd_req_mdata, 14'h1055);
        clear_inputs();
        d = rand512();
        send_rsp(14'h1055, d);
        step();
        check_eq("rt_rsp_valid", io_rsp_valid, 4'b0010);
        check_eq("rt_rsp_mdata", io_rsp_mdata, 12'h055);
        check_eq("rt_rsp_data", io_rsp_data, d);

        // Back-pressure: nothing granted while almost full
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 20'(32'h30000 + i), 12'(i));
        io_qpi_rd_req_almostfull = 1'b1;
        for (int k = 0; k < 5; k++) step();
        io_qpi_rd_req_almostfull = 1'b0;
        step();
        check_eq("af_resume_id", io_qpi_rd_req_mdata[13:12], 2'd2);
        check_eq("af_resume_valid", io_qpi_rd_req_valid, 1'b1);

        // Outstanding limit on requester 3
        do_reset();
        set_req(3, 20'h0F0F0, 12'hABC);
        for (int k = 0; k < MAX_OUTST; k++) step();
        check_eq("limit_not_ready", io_req_ready[3], 1'b0);
        send_rsp({2'd3, 12'hABC}, rand512());
        step();
        check_eq("limit_ready_again", io_req_ready[3], 1'b1);
        step();
        clear_inputs();

        // Accept and response in the same cycle, then a stray response
        do_reset();
        set_req(0, 20'h00100, 12'h010);
        for (int k = 0; k < 3; k++) step();
        send_rsp(14'h0010, rand512());
        step();
        clear_inputs();
        send_rsp(14'h2000, rand512());
        step();
        step();
        check_eq("stray_no_rsp", io_rsp_valid, '0);
        for (int k = 0; k < 3; k++) begin
            send_rsp(14'h0010, rand512());
            step();
        end
        step();
        check_eq("drained_idle", io_idle, 1'b1);

        // Reset while reads are in flight
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 20'(32'h40000 + i), 12'(i));
        for (int k = 0; k < 5; k++) step();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 20'(32'h50000 + i), 12'(i));
        step();
        check_eq("post_rst_grant", io_qpi_rd_req_mdata[13:12], 2'd0);
        clear_inputs();
        send_rsp(14'h1001, rand512());
        step();

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            io_req_valid             = NUM_REQ'($urandom);
            io_req_addr              = {$urandom, $urandom, $urandom};
            io_req_mdata             = {$urandom, $urandom};
            io_qpi_rd_req_almostfull = ($urandom_range(4) == 0);
            if ($urandom_range(7) == 0) begin
                send_rsp(14'($urandom), rand512());
            end else if (pend.size() > 0 && $urandom_range(1) == 1) begin
                int j = $urandom_range(pend.size() - 1);
                send_rsp(pend[j], rand512());
                pend.delete(j);
            end
            step();
        end
        clear_inputs();

`ifdef QPI_RD_ARB_PERF_EN
        @(negedge clk);
        check_eq("perf_grants", io_perf_grants, 32'(m_grants));
        check_eq("perf_stalls", io_perf_stalls, 32'(m_stalls));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_qpi_rd_arbiter
`default_nettype wire

// File: doc/qpi_rd_arbiter.md
QPI_RD_ARBITER -- requirements
Module: qpi_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read requesters (power of 2, 2..4).
REQ-002 SHALL have parameter MAX_OUTST, default 16, per-requester outstanding read limit (1..63).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port io_req_valid  in  NUM_REQ  per-requester request valid.
REQ-006 SHALL have port io_req_addr  in  NUM_REQ*20  packed request addresses, requester i at bits [20i+19:20i].
REQ-007 SHALL have port io_req_mdata  in  NUM_REQ*12  packed requester-local tags.
REQ-008 SHALL have port io_req_ready  out  NUM_REQ  request accepted this cycle when valid&ready.
REQ-009 SHALL have port io_qpi_rd_req_almostfull  in  1  QPI read queue back-pressure.
REQ-010 SHALL have ports io_qpi_rd_req_addr/mdata/valid  out  20/14/1  QPI read request.
REQ-011 SHALL have ports io_qpi_rd_rsp_valid/mdata/data  in  1/14/512  QPI read response.
REQ-012 SHALL have ports io_rsp_valid  out  NUM_REQ, io_rsp_mdata  out  12, io_rsp_data  out  512  routed response.
REQ-013 SHALL have port io_idle  out  1  no outstanding reads and no registered request pending.

Function
REQ-014 SHALL grant at most one requester per cycle, round-robin: search starts at (last_grant+1) mod NUM_REQ.
REQ-015 SHALL drive io_req_ready[i]=1 only for the selected requester, only when io_req_valid[i]=1, almostfull=0 and outst[i]<MAX_OUTST; combinational from current state.
REQ-016 SHALL update last_grant only on an accepted request; no acceptance leaves pointer unchanged.
REQ-017 SHALL register the accepted request: io_qpi_rd_req_valid=1 for exactly the following cycle, addr=requester addr, mdata={2'(i), req_mdata} (id in bits [13:12]).
REQ-018 SHALL keep io_qpi_rd_req_valid=0 with addr/mdata holding last value when nothing accepted.
REQ-019 SHALL route a response with rd_rsp_valid=1 to io_rsp_valid[mdata[13:12]] one cycle later, with io_rsp_mdata=mdata[11:0], io_rsp_data=data; all other io_rsp_valid bits 0.
REQ-020 SHALL increment outst[i] on acceptance, decrement on routed response, hold when both occur in the same cycle.
REQ-021 SHALL ignore (no route, no decrement) a response whose id >= NUM_REQ or whose outst[id]=0; in that case no counter underflow.
REQ-022 SHALL drive io_idle=1 iff all outst[i]=0 and io_qpi_rd_req_valid=0.
REQ-023 SHALL grant nothing while almostfull=1; requests resume in the first cycle almostfull=0.

Reset
REQ-024 SHALL, on reset=0, clear immediately: io_qpi_rd_req_valid=0, addr=0, mdata=0, io_rsp_valid=0, io_rsp_mdata=0, io_rsp_data=0, all outst=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-025 SHALL drop in-flight counts on reset mid-operation; responses arriving after release for pre-reset reads are discarded per REQ-021.

Configuration
REQ-026 SHALL, with QPI_RD_ARB_PERF_EN defined, add outputs io_perf_grants (32) counting accepted requests and io_perf_stalls (32) counting cycles with any valid request but no grant; both saturate at all-ones and reset to 0.
REQ-027 SHALL, without QPI_RD_ARB_PERF_EN, omit these ports and counters; all other behaviour identical.

Structure
REQ-028 SHALL place QPI widths (ADDR 20, MDATA 14, DATA 512), ID width 2 and local-tag width 12 in shared package qpi_pkg.
REQ-029 SHALL use one sub-module rr_arbiter (NUM_REQ-wide request/grant vector with pointer input) for grant selection.

Verification
REQ-030 Requester 0 and 2 valid continuously, almostfull=0 -> grants alternate 0,2,0,2; rd_req_mdata[13:12] sequence 0,2,0,2, one cycle after each ready.
REQ-031 Requester 1 issues addr 0x00ABC tag 0x055 -> next cycle rd_req_addr=0x00ABC, mdata=0x1055; response mdata 0x1055 data D -> one cycle later io_rsp_valid=4'b0010, io_rsp_mdata=0x055, io_rsp_data=D.
REQ-032 almostfull=1 for 5 cycles with all valid -> io_req_ready=0, rd_req_valid=0 throughout; first cycle after deassert grants the next requester in round-robin order.
REQ-033 Requester 3 issues 16 reads, no responses -> 17th request not ready; one response for id 3 -> ready re-asserted the following cycle.
REQ-034 Acceptance and response for requester 0 in the same cycle with outst=3 -> outst stays 3; response with mdata 0x2000 while outst[2]=0 -> no io_rsp_valid, no underflow.
REQ-035 reset pulsed low with 5 reads outstanding -> all outputs 0 immediately, io_idle=1 after release, first grant goes to requester 0.
